// File: rtl/seq_divider_pkg.sv
// Shared state encodings, default data width and the 4-bit carry-lookahead
// group used to build the divider's add/subtract datapath.
package seq_divider_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ITER = 3'd1;
  localparam logic [2:0] S_FIX  = 3'd2;
  localparam logic [2:0] S_SIGN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Returns {carry_out, sum[3:0]} with all group carries computed in parallel.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

endpackage

// File: rtl/seq_divider_cla_addsub.sv
// W-bit add/subtract (s = sub ? a - b : a + b) built from rippled 4-bit CLA groups.
module seq_divider_cla_addsub
  import seq_divider_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);

  localparam int G  = (W + 3) / 4;
  localparam int PW = G * 4;

  logic [PW-1:0] a_x;
  logic [PW-1:0] b_x;
  logic [PW-1:0] s_x;
  logic [G:0]    c;
  logic          unused_bits;

  assign a_x  = PW'(a);
  assign b_x  = PW'(b) ^ {PW{sub}};
  assign c[0] = sub;

  for (genvar i = 0; i < G; i++) begin : g_grp
    assign {c[i+1], s_x[4*i+3:4*i]} = cla4(a_x[4*i+3:4*i], b_x[4*i+3:4*i], c[i]);
  end

  // Padding bits above W only exist to fill the last 4-bit group.
  assign s           = s_x[W-1:0];
  assign unused_bits = ^{c[G], s_x[PW-1:W]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle non-restoring divider: one partial-remainder add/subtract per cycle,
// quotient to LO and remainder to HI, signed or unsigned.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic             q_neg;
  logic             r_neg;

  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic [WIDTH:0]   add_s;
  logic             add_sub;

  assign sign_a = is_signed & dividend[WIDTH-1];
  assign sign_b = is_signed & divisor[WIDTH-1];
  assign mag_a  = sign_a ? (~dividend + ONE) : dividend;
  assign mag_b  = sign_b ? (~divisor + ONE) : divisor;

  // ITER works on the shifted {P,Q}; FIX restores a negative final P by adding D.
  assign add_a   = (state == S_FIX) ? p : {p[WIDTH-1:0], q[WIDTH-1]};
  assign add_b   = {1'b0, d};
  assign add_sub = (state == S_ITER) && !p[WIDTH];

  seq_divider_cla_addsub #(.W(WIDTH + 1)) u_addsub (
    .sub (add_sub),
    .a   (add_a),
    .b   (add_b),
    .s   (add_s)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state       <= S_IDLE;
      cnt         <= '0;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            q     <= mag_a;
            d     <= mag_b;
            p     <= '0;
            q_neg <= sign_a ^ sign_b;
            r_neg <= sign_a;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              div_by_zero <= 1'b0;
              cnt         <= CW'(WIDTH);
              state       <= S_ITER;
            end
          end
        end
        S_ITER: begin
          p   <= add_s;
          q   <= {q[WIDTH-2:0], ~add_s[WIDTH]};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          if (p[WIDTH]) p <= add_s;
          state <= S_SIGN;
        end
        S_SIGN: begin
          quotient  <= q_neg ? (~q + ONE) : q;
          remainder <= r_neg ? (~p[WIDTH-1:0] + ONE) : p[WIDTH-1:0];
          state     <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
